micro_sequencer: RTL
====================

// Module: micro_sequencer
// PURPOSE
//  Parametrised microprogrammed control unit: a CAR-addressed writable control store drives a
//  registered control word to the datapath (PC/MAR/MBR/IR/ACC/BR/ALU strobes).
//  Next-address logic supports sequential, opcode-mapped, conditional-on-flag and halt sequencing.
//  Adds datapath stall, start/halt handshake and illegal-opcode trap.
//  Sits between IR/flag register and datapath; microcode is loaded over the uc_* port while halted.
// PARAMETERS
//  CW_WIDTH    32  control-word bits driven to datapath
//  CAR_WIDTH   8   control address register width; store depth = 2**CAR_WIDTH
//  OP_WIDTH    8   opcode width
//  FLAG_WIDTH  8   status flag count
//  MAP_SHIFT   3   opcode->entry mapping: entry = opcode << MAP_SHIFT (truncated to CAR_WIDTH)
//  NUM_OPS     17  opcodes 0..NUM_OPS-1 legal
//  TRAP_ADDR   8'hF0  microroutine entry for illegal opcodes
//  Derived: FS_W = clog2(FLAG_WIDTH) (min 1); UW = CW_WIDTH+3+FS_W+CAR_WIDTH
// PORTS
//  clk             in   1          clock, rising edge
//  rst             in   1          asynchronous, active-low reset
//  start           in   1          pulse: leave HALTED, run from CAR=0
//  stall           in   1          datapath not ready: hold CAR, drive control word 0
//  opcode          in   OP_WIDTH   IR opcode, sampled on MAP microop
//  flags           in   FLAG_WIDTH status flags, sampled on BRT/BRF microops
//  uc_we           in   1          control-store write strobe (honoured only when !running)
//  uc_waddr        in   CAR_WIDTH  control-store write address
//  uc_wdata        in   UW         microword {ctrl[CW], seq[3], fsel[FS_W], baddr[CAR]}
//  control_signal  out  CW_WIDTH   registered control word to datapath
//  car_out         out  CAR_WIDTH  current CAR (debug)
//  running         out  1          1 = RUN state
//  illegal_op      out  1          one-cycle pulse on MAP of opcode >= NUM_OPS
// BEHAVIOUR
//  - Reset (async, immediate): state=HALTED, car=0, control_signal=0, illegal_op=0.
//    Control-store contents are NOT cleared.
//  - States: HALTED -(start)-> RUN; RUN -(HALT microop issued)-> HALTED. start in RUN is ignored.
//  - HALTED: control_signal=0, car held at 0; uc_we writes store[uc_waddr] at clk edge.
//  - RUN, stall=1: car held, control_signal<=0, no flag/opcode sampling; uc_we ignored.
//  - RUN, stall=0, each edge, with w=store[car] (combinational read):
//      control_signal <= w.ctrl (latency 1 cycle from CAR); car <= next:
//      seq 0 NEXT : car+1, wraps 2**CAR_WIDTH-1 -> 0
//      seq 1 MAP  : opcode<NUM_OPS ? opcode<<MAP_SHIFT : TRAP_ADDR (illegal_op=1 that cycle)
//      seq 2 FETCH: 0
//      seq 3 BRT  : flags[fsel] ? baddr : car+1
//      seq 4 BRF  : !flags[fsel] ? baddr : car+1
//      seq 5 JUMP : baddr
//      seq 6 HALT : car<=0, state<=HALTED; this word's ctrl still issued once
//      seq 7      : reserved, treated as NEXT
//    fsel >= FLAG_WIDTH reads as flag 0 (false).
//  - Start and stall same cycle: enter RUN; first word issued on first stall=0 cycle.
//  - uc_we coincident with start: write is performed (still halted at that edge).
//  - illegal_op: registered, high exactly one cycle per trapped MAP; 0 otherwise.
//  - Reset mid-routine: outputs cleared asynchronously; start required to resume.
// TESTING
//  1 Reset then load: store[0]={ctrl=32'h20,NEXT}, [1]={32'h10,HALT}; start -> control_signal
//    32'h20 then 32'h10 on consecutive cycles, then 0; running falls after the HALT word.
//  2 Map: store[2]=MAP, opcode=8'h03 -> car_out=8'h18 next cycle; opcode=8'h40
//    -> car_out=TRAP_ADDR, illegal_op high 1 cycle.
//  3 Branch: BRF fsel=0 baddr=8'h30 with flags[0]=0 -> car 8'h30; flags[0]=1 -> car+1.
//  4 Stall: assert stall 3 cycles mid-routine -> car_out frozen, control_signal=0,
//    sequence resumes unchanged.
//  5 Wrap/guards: NEXT at car=8'hFF -> 8'h00; uc_we while running -> store unchanged (readback after halt).
//  6 Async rst low mid-RUN between edges -> control_signal=0, running=0 immediately; store intact.

Source files
------------

// File: rtl/micro_sequencer.sv
// micro_sequencer: microprogrammed control unit driving a registered control word from a writable control store
module micro_sequencer #(
  parameter int CW_WIDTH = 32,
  parameter int CAR_WIDTH = 8,
  parameter int OP_WIDTH = 8,
  parameter int FLAG_WIDTH = 8,
  parameter int MAP_SHIFT = 3,
  parameter int NUM_OPS = 17,
  parameter logic [CAR_WIDTH-1:0] TRAP_ADDR = CAR_WIDTH'(8'hF0),
  localparam int FS_W = (FLAG_WIDTH > 1) ? $clog2(FLAG_WIDTH) : 1,
  localparam int UW = CW_WIDTH + 3 + FS_W + CAR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stall,
  input  logic [OP_WIDTH-1:0]   opcode,
  input  logic [FLAG_WIDTH-1:0] flags,
  input  logic                  uc_we,
  input  logic [CAR_WIDTH-1:0]  uc_waddr,
  input  logic [UW-1:0]         uc_wdata,
  output logic [CW_WIDTH-1:0]   control_signal,
  output logic [CAR_WIDTH-1:0]  car_out,
  output logic                  running,
  output logic                  illegal_op
);
  typedef enum logic {HALTED, RUN} state_t;
  state_t state_q, state_d;
  logic [CAR_WIDTH-1:0] car_q, car_d, car_inc, map_addr, baddr;
  logic [CW_WIDTH-1:0] cs_q, cs_d, ctrl;
  logic ill_q, ill_d, flag, legal;
  logic [2:0] seq;
  logic [FS_W-1:0] fsel;
  logic [UW-1:0] store [2**CAR_WIDTH];
  assign {ctrl, seq, fsel, baddr} = store[car_q];
  assign car_inc = car_q + CAR_WIDTH'(1);
  assign legal = 32'(opcode) < NUM_OPS;
  assign map_addr = CAR_WIDTH'((CAR_WIDTH + OP_WIDTH)'(opcode) << MAP_SHIFT);
  assign flag = (32'(fsel) < FLAG_WIDTH) ? flags[fsel] : 1'b0;
  assign control_signal = cs_q;
  assign car_out = car_q;
  assign running = state_q == RUN;
  assign illegal_op = ill_q;
  // control store is loadable only while halted and survives reset
  always_ff @(posedge clk)
    if (uc_we && state_q == HALTED) store[uc_waddr] <= uc_wdata;
  // sequencer state, address and registered outputs
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= HALTED;
      car_q <= '0;
      cs_q <= '0;
      ill_q <= 1'b0;
    end else begin
      state_q <= state_d;
      car_q <= car_d;
      cs_q <= cs_d;
      ill_q <= ill_d;
    end
  // next-address selection; a stall freezes the address and blanks the control word
  always_comb begin
    state_d = state_q;
    car_d = car_q;
    cs_d = '0;
    ill_d = 1'b0;
    if (state_q == HALTED) begin
      car_d = '0;
      if (start) state_d = RUN;
    end else if (!stall) begin
      cs_d = ctrl;
      case (seq)
        3'd1: begin
          car_d = legal ? map_addr : TRAP_ADDR;
          ill_d = !legal;
        end
        3'd2: car_d = '0;
        3'd3: car_d = flag ? baddr : car_inc;
        3'd4: car_d = flag ? car_inc : baddr;
        3'd5: car_d = baddr;
        3'd6: begin
          car_d = '0;
          state_d = HALTED;
        end
        default: car_d = car_inc;
      endcase
    end
  end
endmodule
